vga_timing_decoder: RTL and testbench



---
 rtl/vga_timing_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and data-enable
// from active-low HS/VS, measures line/frame timing and qualifies lock.
module vga_timing_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       de,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] H_START = 10'(H_PULSE + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_PULSE + H_BACK + H_ACTIVE);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_START = 10'(V_PULSE + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_PULSE + V_BACK + V_ACTIVE);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       hs_r_q, vs_r_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vs_pend_q, vs_pend_d;
  logic       line_mm_q, line_mm_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;
  logic [3:0] good_q, good_d;
  logic       err_d;
  logic       win_s1_q, win_s1_d;
  logic [9:0] x_s1_q, x_s1_d;
  logic [9:0] y_s1_q, y_s1_d;
  logic       de_q, de_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       frame_start_q, locked_q, sync_err_q;

  logic hs_fall, vs_fall, frame_ev, len_bad, frame_good, watchdog;

  // h_cnt counts clocks since the last HS falling edge, so at the next edge
  // it already holds the full line length.
  assign hs_fall    = hs_r_q & ~hs_in;
  assign vs_fall    = vs_r_q & ~vs_in;
  assign frame_ev   = hs_fall & (vs_pend_q | vs_fall);
  assign len_bad    = (h_cnt_q != H_TOT);
  assign frame_good = ~line_mm_q & ~len_bad & ((v_cnt_q + 10'd1) == V_TOT);
  assign watchdog   = ~hs_fall & ((h_cnt_q == CNT_MAX) | (v_cnt_q == CNT_MAX));

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    vs_pend_d     = vs_pend_q;
    line_mm_d     = line_mm_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    if (hs_fall) begin
      line_len_d = h_cnt_q;
      h_cnt_d    = 10'd1;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // The line closed by a frame edge belongs to the old frame; it is judged
    // by the FSM directly, so the mismatch flag starts clean for the new one.
    if (frame_ev) begin
      frame_lines_d = v_cnt_q + 10'd1;
      v_cnt_d       = 10'd0;
      vs_pend_d     = 1'b0;
      line_mm_d     = 1'b0;
    end else begin
      if (vs_fall) vs_pend_d = 1'b1;
      if (hs_fall) begin
        if (v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;
        if (len_bad) line_mm_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (watchdog) begin
      state_d = ST_SEARCH;
      good_d  = 4'd0;
      err_d   = (state_q == ST_LOCKED);
    end else if (frame_ev) begin
      unique case (state_q)
        ST_SEARCH: begin
          state_d = ST_CHECK;
          good_d  = 4'd0;
        end
        ST_CHECK: begin
          if (frame_good) begin
            good_d = good_q + 4'd1;
            if ((good_q + 4'd1) >= LOCK_N) begin
              state_d = ST_LOCKED;
              good_d  = 4'd0;
            end
          end else begin
            good_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            state_d = ST_SEARCH;
            good_d  = 4'd0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          good_d  = 4'd0;
        end
      endcase
    end
  end

  // Two-stage pixel pipeline: window decode, then lock gating and zeroing.
  always_comb begin
    win_s1_d  = ~hs_fall & (h_cnt_q >= H_START) & (h_cnt_q < H_END) &
                (v_cnt_q >= V_START) & (v_cnt_q < V_END);
    x_s1_d    = h_cnt_q - H_START;
    y_s1_d    = v_cnt_q - V_START;
    de_d      = win_s1_q & (state_q == ST_LOCKED);
    pixel_x_d = de_d ? x_s1_q : 10'd0;
    pixel_y_d = de_d ? y_s1_q : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      hs_r_q        <= 1'b1;
      vs_r_q        <= 1'b1;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      vs_pend_q     <= 1'b0;
      line_mm_q     <= 1'b0;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      good_q        <= 4'd0;
      win_s1_q      <= 1'b0;
      x_s1_q        <= 10'd0;
      y_s1_q        <= 10'd0;
      de_q          <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_r_q        <= hs_in;
      vs_r_q        <= vs_in;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vs_pend_q     <= vs_pend_d;
      line_mm_q     <= line_mm_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      good_q        <= good_d;
      win_s1_q      <= win_s1_d;
      x_s1_q        <= x_s1_d;
      y_s1_q        <= y_s1_d;
      de_q          <= de_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_ev;
      locked_q      <= (state_q == ST_LOCKED);
      sync_err_q    <= err_d;
    end
  end

  assign de          = de_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a scaled-down 32x16 raster
// (4 sync + 6 back porch + 16 active clocks; 2 sync + 3 back porch + 8 active lines).
module tb_vga_timing_decoder;

  localparam int HP = 4;
  localparam int HB = 6;
  localparam int HA = 16;
  localparam int HT = 32;
  localparam int VP = 2;
  localparam int VB = 3;
  localparam int VA = 8;
  localparam int VT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       de, frame_start, locked, sync_err;
  logic [9:0] pixel_x, pixel_y, line_len, frame_lines;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   fs_cnt = 0;
  int   err_cnt = 0;
  int   last_fs_cyc = 0;
  int   last_err_cyc = 0;
  int   lock_rise_cyc = 0;
  int   lock_rise_fs = 0;
  int   lock_fall_cyc = 0;
  logic prev_locked = 1'b0;

  logic       sb_on = 1'b0;
  int         de_cnt = 0;
  int         first_de_cyc = -1;
  int         last_de_cyc = 0;
  logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
  logic [19:0] exp_q[$];

  int fs_err = 0;
  int fs_bad = 0;

  vga_timing_decoder #(
    .H_ACTIVE(HA), .H_PULSE(HP), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_PULSE(VP), .V_BACK(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .de(de),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .frame_start(frame_start),
    .locked(locked),
    .sync_err(sync_err),
    .line_len(line_len),
    .frame_lines(frame_lines),
    .dbg_state(dbg_state)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish in time (got running, want finished)");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // one clock: sample outputs 1ns after the edge and update the event log
  task automatic step();
    logic [19:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_start) begin
      fs_cnt++;
      last_fs_cyc = cyc;
    end
    if (sync_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (locked && !prev_locked) begin
      lock_rise_cyc = cyc;
      lock_rise_fs  = fs_cnt;
    end
    if (!locked && prev_locked) lock_fall_cyc = cyc;
    prev_locked = locked;
    if (sb_on && de) begin
      de_cnt++;
      if (first_de_cyc < 0) begin
        first_de_cyc = cyc;
        first_x = pixel_x;
        first_y = pixel_y;
      end
      last_de_cyc = cyc;
      last_x = pixel_x;
      last_y = pixel_y;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '1;
      check_eq("pixel_xy", {pixel_x, pixel_y}, e);
    end
  endtask

  // driver tasks
  task automatic drive_cycle(input int line, input int col);
    hs_in = (col < HP) ? 1'b0 : 1'b1;
    vs_in = (line < VP) ? 1'b0 : 1'b1;
    if (sb_on && line >= VP + VB && line < VP + VB + VA && col >= HP + HB && col < HP + HB + HA)
      exp_q.push_back({10'(col - HP - HB), 10'(line - VP - VB)});
    step();
  endtask

  task automatic drive_lines(input int first, input int last, input int stretch);
    for (int l = first; l <= last; l++) begin
      for (int c = 0; c < ((l == stretch) ? HT + 1 : HT); c++) drive_cycle(l, c);
    end
  endtask

  task automatic hold_high(input int n);
    hs_in = 1'b1;
    vs_in = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst_flags", {de, frame_start, locked, sync_err}, 0);
    check_eq("rst_pixel", {pixel_x, pixel_y}, 0);
    check_eq("rst_len", {line_len, frame_lines}, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b0;

    // standard stream from reset: lock one cycle after the third frame_start
    drive_lines(0, VT - 1, -1);
    check_eq("fs_first", fs_cnt, 1);
    check_eq("state_check", dbg_state, 1);
    drive_lines(0, VT - 1, -1);
    drive_lines(0, VT - 1, -1);
    check_eq("lock_fs_idx", lock_rise_fs, 3);
    check_eq("lock_delay", lock_rise_cyc - last_fs_cyc, 1);
    check_eq("locked_std", locked, 1);
    check_eq("line_len_std", line_len, HT);
    check_eq("frame_lines_std", frame_lines, VT);
    check_eq("no_err_std", err_cnt, 0);

    // one locked frame through the pixel scoreboard
    sb_on = 1'b1;
    drive_lines(0, VT - 1, -1);
    sb_on = 1'b0;
    check_eq("de_count", de_cnt, HA * VA);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("first_de_delay", first_de_cyc - last_fs_cyc, (VP + VB) * HT + (HP + HB) + 1);
    check_eq("first_de_xy", {first_x, first_y}, 0);
    check_eq("last_de_delay", last_de_cyc - last_fs_cyc, 12 * HT + 25 + 1);
    check_eq("last_de_x", last_x, HA - 1);
    check_eq("last_de_y", last_y, VA - 1);

    // one line stretched by a clock: error deferred to the next frame_start
    drive_lines(0, 8, 8);
    drive_lines(9, 9, -1);
    check_eq("stretch_len", line_len, HT + 1);
    check_eq("stretch_still_locked", locked, 1);
    check_eq("stretch_no_err_yet", err_cnt, 0);
    drive_lines(10, VT - 1, -1);
    drive_lines(0, 0, -1);
    check_eq("stretch_err", err_cnt, 1);
    check_eq("stretch_err_at_fs", last_err_cyc - last_fs_cyc, 0);
    check_eq("stretch_unlock_delay", lock_fall_cyc - last_err_cyc, 1);
    check_eq("stretch_unlocked", locked, 0);
    check_eq("stretch_state", dbg_state, 0);
    fs_err = fs_cnt;
    drive_lines(1, VT - 1, -1);
    drive_lines(0, VT - 1, -1);
    drive_lines(0, VT - 1, -1);
    drive_lines(0, 0, -1);
    check_eq("relock_fs", lock_rise_fs - fs_err, 3);
    check_eq("relocked", locked, 1);
    check_eq("relock_err", err_cnt, 1);

    // HS stuck high while locked: watchdog, single error pulse
    drive_lines(1, 3, -1);
    hold_high(1100);
    check_eq("wd_err", err_cnt, 2);
    check_eq("wd_unlock_delay", lock_fall_cyc - last_err_cyc, 1);
    check_eq("wd_locked", locked, 0);
    check_eq("wd_de", de, 0);
    check_eq("wd_state", dbg_state, 0);
    hold_high(200);
    check_eq("wd_single", err_cnt, 2);
    drive_lines(0, 0, -1);
    check_eq("wd_sat_len", line_len, 1023);
    check_eq("wd_resume_state", dbg_state, 1);

    // short frame in CHECK after one good frame: count restarts, no error
    drive_lines(1, VT - 1, -1);
    drive_lines(0, VT - 2, -1);
    drive_lines(0, 0, -1);
    check_eq("short_lines", frame_lines, VT - 1);
    check_eq("short_no_err", err_cnt, 2);
    check_eq("short_state", dbg_state, 1);
    check_eq("short_unlocked", locked, 0);
    fs_bad = fs_cnt;
    drive_lines(1, VT - 1, -1);
    drive_lines(0, VT - 1, -1);
    drive_lines(0, 0, -1);
    check_eq("short_relock_fs", lock_rise_fs - fs_bad, 2);
    check_eq("short_relocked", locked, 1);

    // synchronous reset mid active line while locked
    drive_lines(1, 6, -1);
    for (int c = 0; c < 15; c++) drive_cycle(7, c);
    check_eq("pre_rst_de", de, 1);
    check_eq("pre_rst_xy", {pixel_x, pixel_y}, {10'd3, 10'd2});
    rst = 1'b1;
    drive_cycle(7, 15);
    rst = 1'b0;
    check_eq("mid_rst_flags", {de, frame_start, locked, sync_err}, 0);
    check_eq("mid_rst_pixel", {pixel_x, pixel_y}, 0);
    check_eq("mid_rst_len", {line_len, frame_lines}, 0);
    check_eq("mid_rst_state", dbg_state, 0);
    for (int c = 16; c < HT; c++) drive_cycle(7, c);
    drive_lines(8, VT - 1, -1);
    drive_lines(0, 0, -1);
    check_eq("post_rst_partial", frame_lines, 9);
    check_eq("post_rst_state", dbg_state, 1);
    check_eq("post_rst_unlocked", locked, 0);
    drive_lines(1, VT - 1, -1);
    drive_lines(0, 0, -1);
    check_eq("post_rst_vcnt0", frame_lines, VT);
    check_eq("err_total", err_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
